// File: rtl/cvsd_decoder.sv
// cvsd_decoder: CVSD bitstream to 8-bit waveform with syllabic step adaptation, IIR smoothing and overload flag
module cvsd_decoder #(
  parameter int RUN_LEN    = 3,
  parameter int STEP_MIN   = 1,
  parameter int STEP_MAX   = 32,
  parameter int STEP_INC   = 2,
  parameter int FILT_SHIFT = 2
) (
  input  logic       clk_10k,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] xr,
  output logic [7:0] xf,
  output logic [7:0] step,
  output logic       out_valid,
  output logic       flag
);
  localparam int HW = RUN_LEN - 1;
  localparam int CW = $clog2(RUN_LEN);
  logic [HW-1:0] hist;
  logic [CW-1:0] cnt;
  logic v, coin;
  logic [8:0] s_inc, x_up;
  logic signed [8:0] x_dn, d;
  logic signed [9:0] f_sum;
  logic [7:0] step_next, xr_next, xf_next;
  always_comb begin
    coin = (cnt == CW'(HW)) && (bit_in ? &hist : ~|hist);
    s_inc = {1'b0, step} + 9'(STEP_INC);
    step_next = coin ? (s_inc > 9'(STEP_MAX) ? 8'(STEP_MAX) : s_inc[7:0])
                     : (step > 8'(STEP_MIN) ? step - 8'd1 : 8'(STEP_MIN));
    x_up = {1'b0, xr} + {1'b0, step_next};
    x_dn = $signed({1'b0, xr}) - $signed({1'b0, step_next});
    xr_next = bit_in ? (x_up[8] ? 8'hff : x_up[7:0]) : (x_dn < 0 ? 8'h00 : x_dn[7:0]);
    d = $signed({1'b0, xr}) - $signed({1'b0, xf});
    f_sum = $signed({2'b00, xf}) + $signed({d[8], d >>> FILT_SHIFT});
    xf_next = f_sum < 0 ? 8'h00 : (f_sum > 10'sd255 ? 8'hff : f_sum[7:0]);
  end
  always_ff @(posedge clk_10k)
    if (!rst_n) begin
      xr <= 8'd128;
      xf <= 8'd128;
      step <= 8'(STEP_MIN);
      hist <= '0;
      cnt <= '0;
      v <= 1'b0;
      out_valid <= 1'b0;
      flag <= 1'b0;
    end else begin
      v <= en;
      out_valid <= v;
      if (v) xf <= xf_next;
      if (en) begin
        step <= step_next;
        xr <= xr_next;
        flag <= step_next == 8'(STEP_MAX);
        hist <= HW'({hist, bit_in});
        cnt <= cnt == CW'(HW) ? cnt : cnt + CW'(1);
      end
    end
endmodule

// File: tb/tb_cvsd_decoder.sv
// tb_cvsd_decoder: directed and random checks of cvsd_decoder against an integer reference model
module tb_cvsd_decoder;
  localparam int RL = 3, SMIN = 1, SMAX = 32, SINC = 2, FDIV = 4;
  logic clk_10k = 0, rst_n = 0, en = 0, bit_in = 0;
  logic [7:0] xr, xf, step;
  logic out_valid, flag;
  int n_cmp = 0, n_bad = 0;
  int m_xr = 128, m_xf = 128, m_step = SMIN, m_flag = 0, m_ov = 0, m_pend = 0;
  int hist[$];
  int ones_xr[13] = '{129, 130, 133, 138, 145, 154, 165, 178, 193, 210, 229, 250, 255};

  cvsd_decoder dut (
    .clk_10k(clk_10k), .rst_n(rst_n), .en(en), .bit_in(bit_in),
    .xr(xr), .xf(xf), .step(step), .out_valid(out_valid), .flag(flag)
  );

  always #5 clk_10k = ~clk_10k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input bit r, input bit e, input bit b);
    int dd, s;
    bit run;
    if (!r) begin
      m_xr = 128; m_xf = 128; m_step = SMIN; m_flag = 0; m_ov = 0; m_pend = 0;
      hist.delete();
      return;
    end
    m_ov = m_pend;
    if (m_pend) begin
      dd = m_xr - m_xf;
      m_xf += dd < 0 ? -((-dd + FDIV - 1) / FDIV) : dd / FDIV;
      m_xf = m_xf < 0 ? 0 : (m_xf > 255 ? 255 : m_xf);
    end
    m_pend = e;
    if (e) begin
      run = hist.size() >= RL - 1;
      for (int i = 1; i < RL; i++)
        if (run && hist[hist.size() - i] != b) run = 0;
      s = run ? m_step + SINC : m_step - 1;
      s = s > SMAX ? SMAX : (s < SMIN ? SMIN : s);
      m_step = s;
      m_flag = s == SMAX;
      m_xr = b ? m_xr + s : m_xr - s;
      m_xr = m_xr > 255 ? 255 : (m_xr < 0 ? 0 : m_xr);
      hist.push_back(b);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit b);
    rst_n = r; en = e; bit_in = b;
    @(posedge clk_10k);
    model(r, e, b);
    #1;
    chk("xr", xr, m_xr);
    chk("xf", xf, m_xf);
    chk("step", step, m_step);
    chk("flag", flag, m_flag);
    chk("out_valid", out_valid, m_ov);
  endtask

  initial begin
    logic [7:0] sxr, sst, pxf;
    logic sfl;
    bit rb;
    // reset and idle
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0);
      chk("rst_xr", xr, 128); chk("rst_xf", xf, 128); chk("rst_step", step, 1);
      chk("rst_flag", flag, 0); chk("rst_ov", out_valid, 0);
    end
    // alternating pattern
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, i % 2 == 0);
      chk("alt_step", step, 1);
      chk("alt_xr", xr, i % 2 == 0 ? 129 : 128);
      chk("alt_ov", out_valid, i > 0);
    end
    // constant ones from reset
    cyc(0, 0, 0);
    for (int i = 0; i < 25; i++) begin
      cyc(1, 1, 1);
      if (i < 13) chk("ones_xr", xr, ones_xr[i]);
      if (i < 3) chk("ones_step", step, i < 2 ? 1 : 3);
      if (i == 16) chk("ones_flag17", flag, 0);
      if (i >= 17) begin chk("ones_step_max", step, 32); chk("ones_flag", flag, 1); end
    end
    cyc(1, 1, 0);
    chk("zero_step", step, 31); chk("zero_flag", flag, 0); chk("zero_xr", xr, 224);
    // filter settle high, then decay
    pxf = xf;
    for (int i = 0; i < 60; i++) begin
      cyc(1, 1, 1);
      if (i > 2) chk("xf_mono_up", xf >= pxf, 1);
      pxf = xf;
    end
    chk("xr_sat", xr, 255);
    chk("xf_settle", xf, 252);
    for (int i = 0; i < 100; i++) cyc(1, 1, 0);
    chk("xr_floor", xr, 0);
    chk("xf_decay", xf, 0);
    // en gating mid-ramp
    cyc(0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1);
    sxr = xr; sst = step; sfl = flag;
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 1);
      chk("gate_xr", xr, sxr); chk("gate_step", step, sst); chk("gate_flag", flag, sfl);
      chk("gate_ov", out_valid, k == 0);
    end
    cyc(1, 1, 1);
    chk("gate_resume_step", step, sst + 2);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1);
    // mid-stream reset at overload
    cyc(0, 0, 0);
    for (int i = 0; i < 18; i++) cyc(1, 1, 1);
    chk("pre_rst_step", step, 32);
    cyc(0, 1, 1);
    chk("mrst_xr", xr, 128); chk("mrst_xf", xf, 128); chk("mrst_step", step, 1); chk("mrst_flag", flag, 0);
    cyc(1, 1, 1);
    chk("mrst_ov", out_valid, 0); chk("post_rst_step1", step, 1);
    cyc(1, 1, 1);
    chk("post_rst_step2", step, 1);
    cyc(1, 1, 1);
    chk("post_rst_step3", step, 3);
    // randomized run with sticky bits, gaps and occasional resets
    rb = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      cyc($urandom_range(0, 80) != 0, $urandom_range(0, 4) != 0, rb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
